// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a two-half-adder full-adder cell and a carry flip-flop.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   ra_q;
  logic [WIDTH-1:0]   rb_q;
  logic [WIDTH-1:0]   rs_q;
  logic [WIDTH-1:0]   sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q;
  logic               cout_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic               p;
  logic               g1;
  logic               s;
  logic               g2;
  logic               c_d;
  logic [WIDTH-1:0]   rs_d;

  // Full adder on the current LSBs: two half-adder cells plus the carry OR
  always_comb begin
    p    = ra_q[0] ^ rb_q[0];
    g1   = ra_q[0] & rb_q[0];
    s    = p ^ c_q;
    g2   = p & c_q;
    c_d  = g1 | g2;
    rs_d = {s, rs_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ra_q        <= '0;
      rb_q        <= '0;
      rs_q        <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            ra_q       <= a;
            rb_q       <= b;
            c_q        <= cin;
            cnt_q      <= '0;
            rs_q       <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          ra_q <= ra_q >> 1;
          rb_q <= rb_q >> 1;
          rs_q <= rs_d;
          c_q  <= c_d;
          // Last bit: publish the result and stop the counter short of wrapping
          if (cnt_q == LAST_BIT) begin
            sum_q       <= rs_d;
            cout_q      <= c_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: expected {cout,sum} queued at accept,
// popped and compared when the result handshake completes.
module tb_serial_adder;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  logic [WIDTH:0] sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ta,
                                           input logic [WIDTH-1:0] tb_v,
                                           input logic tc);
    return {1'b0, ta} + {1'b0, tb_v} + (WIDTH+1)'(tc);
  endfunction

  // Present operands and hold in_valid until the accept edge (bounded)
  task automatic accept(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc);
    int t = 0;
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    while (!in_ready && t < 50) begin step(); t++; end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb.push_back(model(ta, tb_v, tc));
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  // Count cycles until out_valid, bounded
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin step(); lat++; end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h required 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_zero();
    int lat;
    logic [WIDTH:0] exp;
    accept('0, '0, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL shift_flags: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    wait_valid(lat);
    n_checks++;
    if (lat != WIDTH) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required %0d", lat, WIDTH);
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_flags: busy=%b in_ready=%b required 0 0", busy, in_ready);
    end
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || exp !== 9'h000) begin
      n_fail++;
      $display("FAIL zero_sum: got %h required 000", {cout, sum});
    end
    take();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL after_take: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  // out_ready already high while shifting: no early handshake
  task automatic test_carry_ripple();
    int lat;
    logic [WIDTH:0] exp;
    out_ready = 1'b1;
    accept(8'hFF, 8'h01, 1'b0);
    wait_valid(lat);
    n_checks++;
    if (lat != WIDTH) begin
      n_fail++;
      $display("FAIL early_ready_latency: got %0d required %0d", lat, WIDTH);
    end
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || {cout, sum} !== 9'h100) begin
      n_fail++;
      $display("FAIL carry_ripple: got %h required 100", {cout, sum});
    end
    step();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_take: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_patterns();
    int lat;
    logic [WIDTH:0] exp;
    logic [WIDTH:0] lit [2];
    lit[0] = 9'h100;
    lit[1] = 9'h0FF;
    for (int i = 0; i < 2; i++) begin
      accept(8'hA5, 8'h5A, (i == 0) ? 1'b1 : 1'b0);
      wait_valid(lat);
      exp = sb.pop_front();
      n_checks++;
      if ({cout, sum} !== exp || {cout, sum} !== lit[i]) begin
        n_fail++;
        $display("FAIL pattern_%0d: got %h required %h", i, {cout, sum}, lit[i]);
      end
      take();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [WIDTH:0] exp;
    int bad = 0;
    accept(8'h12, 8'h34, 1'b1);
    wait_valid(lat);
    exp = sb[0];
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin a = 8'h77; b = 8'h77; cin = 1'b1; in_valid = 1'b1; end
      step();
      in_valid = 1'b0;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d unstable cycles required 0 (sum=%h exp=%h)", bad, {cout, sum}, exp);
    end
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL stall_result: got %h required %h", {cout, sum}, exp);
    end
    take();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: in_ready=%b required 1", in_ready);
    end
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_in_valid: busy=%b out_valid=%b required 0 0", busy, out_valid);
    end
  endtask

  // Result taken and new operands offered in the same cycle
  task automatic test_back_to_back();
    int lat;
    int first_acc;
    logic [WIDTH:0] exp;
    accept(8'h80, 8'h80, 1'b1);
    first_acc = acc_cyc;
    wait_valid(lat);
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL b2b_first: got %h required %h", {cout, sum}, exp);
    end
    a = 8'h0E; b = 8'h71; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_no_bypass: in_ready=%b busy=%b out_valid=%b required 1 0 0",
               in_ready, busy, out_valid);
    end
    @(posedge clk);
    sb.push_back(model(8'h0E, 8'h71, 1'b0));
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (cyc - first_acc != WIDTH + 2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d cycles busy=%b required %0d 1",
               cyc - first_acc, busy, WIDTH + 2);
    end
    wait_valid(lat);
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp) begin
      n_fail++;
      $display("FAIL b2b_second: got %h required %h", {cout, sum}, exp);
    end
    take();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen = 0;
    logic [WIDTH:0] exp;
    accept(8'h3C, 8'h0F, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_checks++;
    if ({in_ready, out_valid, busy, cout, sum} !== {1'b1, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
      n_fail++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b cout=%b sum=%h required 1 0 0 0 00",
               in_ready, out_valid, busy, cout, sum);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL post_reset_idle: %0d bad cycles required 0", seen);
    end
    accept(8'h3C, 8'h0F, 1'b0);
    wait_valid(lat);
    exp = sb.pop_front();
    n_checks++;
    if ({cout, sum} !== exp || {cout, sum} !== 9'h04B) begin
      n_fail++;
      $display("FAIL post_reset_sum: got %h required 04B", {cout, sum});
    end
    take();
  endtask

  task automatic test_random();
    int lat;
    int got_n = 0;
    logic [WIDTH:0] exp;
    for (int i = 0; i < 200; i++) begin
      accept(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      wait_valid(lat);
      repeat ($urandom_range(0, 3)) step();
      if (out_valid === 1'b1 && sb.size() > 0) begin
        exp = sb.pop_front();
        got_n++;
        n_checks++;
        if ({cout, sum} !== exp) begin
          n_fail++;
          $display("FAIL random_%0d: got %h required %h", i, {cout, sum}, exp);
        end
      end
      take();
    end
    n_checks++;
    if (got_n != 200 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL random_count: got %0d results, %0d pending; required 200, 0", got_n, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_carry_ripple();
    test_patterns();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that adds two WIDTH-bit operands LSB-first, one bit per clock.
- The per-bit datapath is a full adder built from two half-adder cells plus an OR gate. A carry flip-flop holds the carry between bits.
- Sits directly downstream of the half-adder cell and is its first sequential consumer. It is the low-area alternative to a ripple-carry adder in the arithmetic library.
- Operands enter through a valid/ready handshake. The result leaves through a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a, b, cin are valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- out_valid  output  1  sum/cout are valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, low WIDTH bits
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, bit counter=0, carry FF=0, operand shift registers=0. Reset takes effect immediately, even mid-operation. An in-flight addition is discarded.
- Registers:
  - shift registers ra, rb (WIDTH bits);
  - result register rs (WIDTH bits);
  - carry FF c;
  - counter cnt, width $clog2(WIDTH), counting 0..WIDTH-1.
- Per-bit datapath (combinational):
  - HA1: ra[0] ^ rb[0] gives p; ra[0] & rb[0] gives g1.
  - HA2: p ^ c gives s; p & c gives g2.
  - Carry: cn = g1 | g2.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: load ra=a, rb=b, c=cin, cnt=0, rs=0; go to SHIFT.
  - Otherwise hold.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle: shift ra and rb right by 1; shift rs right by 1 with s entering the MSB; c=cn; cnt=cnt+1.
  - When cnt==WIDTH-1 (the last bit): perform the shift, latch cout=cn, go to DONE.
  - Inputs are ignored in this state.
- DONE:
  - out_valid=1; sum=rs; cout is held.
  - On out_ready: out_valid=0 and return to IDLE. If out_ready is low, hold all outputs stable indefinitely.
- Latency: accept edge at cycle 0. SHIFT occupies cycles 1..WIDTH. out_valid is high from cycle WIDTH+1. Minimum throughput is one addition per WIDTH+2 cycles.
- sum output:
  - sum is the registered rs, updated only on entry to DONE; sum updates only then.
  - sum holds its last value in IDLE.
  - The bench checks sum and cout only while out_valid=1.
- Arithmetic: {cout, sum} == a + b + cin, computed modulo 2^(WIDTH+1). There is no overflow flag; cout is the unsigned carry.
- Boundary conditions:
  - in_valid asserted during SHIFT or DONE: no effect; the operands are not latched and in_ready stays 0.
  - out_ready high before out_valid: no effect.
  - Simultaneous out_ready in DONE and in_valid: the result is accepted and the state goes to IDLE. New operands are accepted on the next cycle, when in_ready=1. There is no same-cycle bypass.
  - rst asserted during SHIFT: the next state after release is IDLE, and no out_valid pulse appears.
  - cnt is never allowed to wrap. The SHIFT→DONE transition occurs exactly at cnt==WIDTH-1.

Test Plan:
- WIDTH=8, a=8'h00, b=8'h00, cin=0 → out_valid at cycle 9 after accept; sum=8'h00, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Full carry ripple through all 8 serial steps.
- a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, cout=1. Then a=8'hA5, b=8'h5A, cin=0 → sum=8'hFF, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → sum, cout, and out_valid stay stable. in_ready=0 throughout, and an in_valid pulse in this window is ignored. Raise out_ready → in_ready=1 on the next cycle.
- Reset mid-operation: accept a=8'h3C, b=8'h0F, then assert rst at SHIFT cycle 4 → outputs go to their reset values immediately. After release, in_ready=1 and no out_valid. Then a=8'h3C, b=8'h0F, cin=0 → sum=8'h4B, cout=0.
- Randomised sweep: 200 random (a, b, cin) triples with random out_ready stalls → {cout, sum} equals the a+b+cin reference every time, with no dropped or duplicated results.
